ifetch_tag_stage: RTL and testbench
===================================

Name: ifetch_tag_stage

Overview:
- First instruction-fetch stage of the SM.
- Each cycle it picks one active warp round-robin and reads its PC.
- It looks up the L1I tag SRAM and per-way valid bits for that PC's set, then presents the result, registered, to the fetch-data/hit stage.
- Successor to the fixed single-mode tag stage. Adds:
  - parametrised warps, ways, sets and line size;
  - a downstream stall;
  - per-warp PC rollback (branch redirect) with squash;
  - cache fill and invalidate-all ports;
  - fill-to-read bypass.

Parameters:
- NUM_WARPS, 4: warps per SM; power of 2, at least 2.
- NUM_WAYS, 4: L1I associativity.
- NUM_SETS, 64: L1I sets; power of 2.
- LINE_BYTES, 64: cache line size; power of 2.
- ADDR_WIDTH, 32: PC width.
- RESET_PC, 32'h0: initial PC of every warp.
- Derived: OFS_W = log2(LINE_BYTES), SET_W = log2(NUM_SETS), TAG_W = ADDR_WIDTH - OFS_W - SET_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- warp_active  in  NUM_WARPS  per-warp eligibility mask.
- stall  in  1  downstream not ready; hold stage.
- rollback_en  in  1  redirect one warp's PC.
- rollback_warp  in  log2(NUM_WARPS)  warp being redirected.
- rollback_pc  in  ADDR_WIDTH  new PC.
- fill_en  in  1  install a line.
- fill_way  in  log2(NUM_WAYS)  way written by the fill.
- fill_addr  in  ADDR_WIDTH  address of the filled line.
- inval_all  in  1  clear all valid bits.
- ift_valid  out  1  output stage holds a live fetch.
- ift_warp_idx  out  log2(NUM_WARPS)  warp of the live fetch.
- ift_pc  out  ADDR_WIDTH  PC of the live fetch.
- ift_tags  out  NUM_WAYS x TAG_W  tags read for the set.
- ift_way_valid  out  NUM_WAYS  valid bits read for the set.

Behaviour:
- Reset (reset low, async):
  - all PCs = RESET_PC;
  - all valid bits = 0;
  - ift_valid = 0, ift_warp_idx = 0, ift_pc = 0;
  - ift_tags = 0, ift_way_valid = 0;
  - round-robin pointer = 0;
  - tag SRAM contents undefined.
  - Reset mid-operation drops any in-flight fetch.
- Address split: set = pc[OFS_W +: SET_W]; tag = pc[ADDR_WIDTH-1 -: TAG_W].
- Arbitration:
  - Candidates = warp_active with rollback_warp masked off when rollback_en = 1.
  - Grant goes to the first candidate at or after the pointer, wrapping.
  - The pointer moves to grant+1 (mod NUM_WARPS) only when a grant is issued.
  - No candidates: no grant, pointer holds.
- Issue (stall = 0 and grant exists):
  - The granted warp's PC is sent to the tag SRAM read.
  - Its PC register increments by 4, wrapping mod 2^ADDR_WIDTH.
  - Next cycle: ift_valid = 1; ift_warp_idx / ift_pc are the granted warp and its pre-increment PC.
  - ift_tags and ift_way_valid hold that set's contents. Latency is 1 cycle.
- stall = 0 and no grant: next cycle ift_valid = 0.
- stall = 1:
  - No grant, no PC increment, pointer holds.
  - All ift_* outputs hold, including tags (SRAM read address held or output captured).
- Rollback:
  - PC[rollback_warp] <= rollback_pc, regardless of stall.
  - If ift_valid = 1 and ift_warp_idx == rollback_warp, ift_valid clears next cycle, even under stall (squash).
  - A rollback of a warp that is not issued in the same cycle has no other effect on issue.
- Fill:
  - Writes tag(fill_addr) into way fill_way, set(fill_addr).
  - Sets that way's valid bit.
- inval_all: clears every valid bit next cycle.
  - Simultaneous inval_all and fill_en: the fill's valid bit ends at 1 (fill wins for its entry).
- Same-cycle fill and read of the same set: write-first bypass. The output shows the new tag and valid = 1 for fill_way; other ways read normally.
- Same-cycle inval_all and read: ift_way_valid = 0 for all ways, except a same-set fill way, which reads 1.
- Inactive warp: its PC holds. Clearing warp_active does not squash a fetch already in the output stage.

Test Plan:
- Reset, then warp_active = 4'b1111, stall = 0, RESET_PC = 0 -> ift_warp_idx sequence 0,1,2,3,0…; ift_pc 0,0,0,0,4,4…; ift_valid rises 1 cycle after reset deassert.
- warp_active = 4'b1010 after pointer = 0 -> grants alternate 1,3,1,3; warps 0 and 2 keep PC = 0.
- stall high 3 cycles mid-stream (output warp 2, PC 0x8) -> outputs frozen at warp 2 / 0x8 with tags stable; no PC changes; sequence resumes at warp 3.
- Output holds warp 1; rollback_en = 1, rollback_warp = 1, rollback_pc = 0x100, with stall = 1 -> ift_valid drops next cycle; warp 1's next issue has ift_pc = 0x100, next 0x104.
- fill_en way 2, fill_addr = 0x1040, issued in the same cycle as a read of PC 0x1040 -> next cycle ift_way_valid = 4'b0100 and ift_tags[2] = tag(0x1040).
- Lines filled in ways 0 and 1, then inval_all -> subsequent reads of that set give ift_way_valid = 0. inval_all together with a fill of way 3 -> only way 3 valid afterwards.

Source files
------------

// File: rtl/ifetch_tag_stage.sv
// First fetch stage: round-robin warp pick, L1I tag/valid lookup, registered result.
// Carries per-warp PCs, branch rollback with squash, line fill and invalidate-all.
module ifetch_tag_stage #(
  parameter int                    NUM_WARPS  = 4,
  parameter int                    NUM_WAYS   = 4,
  parameter int                    NUM_SETS   = 64,
  parameter int                    LINE_BYTES = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  localparam int WARP_W = $clog2(NUM_WARPS),
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int OFS_W  = $clog2(LINE_BYTES),
  localparam int SET_W  = $clog2(NUM_SETS),
  localparam int TAG_W  = ADDR_WIDTH - OFS_W - SET_W
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_WARPS-1:0]               warp_active_i,
  input  logic                               stall_i,
  input  logic                               rollback_en_i,
  input  logic [WARP_W-1:0]                  rollback_warp_i,
  input  logic [ADDR_WIDTH-1:0]              rollback_pc_i,
  input  logic                               fill_en_i,
  input  logic [WAY_W-1:0]                   fill_way_i,
  input  logic [ADDR_WIDTH-1:0]              fill_addr_i,
  input  logic                               inval_all_i,
  output logic                               ift_valid_o,
  output logic [WARP_W-1:0]                  ift_warp_idx_o,
  output logic [ADDR_WIDTH-1:0]              ift_pc_o,
  output logic [NUM_WAYS-1:0][TAG_W-1:0]     ift_tags_o,
  output logic [NUM_WAYS-1:0]                ift_way_valid_o
);

  logic [NUM_WARPS-1:0][ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]                     tag_mem [NUM_SETS][NUM_WAYS];
  logic [WARP_W-1:0]                    rr_q, rr_d;

  logic                                 ift_valid_q, ift_valid_d;
  logic [WARP_W-1:0]                    ift_warp_q, ift_warp_d;
  logic [ADDR_WIDTH-1:0]                ift_pc_q, ift_pc_d;
  logic [NUM_WAYS-1:0][TAG_W-1:0]       ift_tags_q, ift_tags_d;
  logic [NUM_WAYS-1:0]                  ift_wv_q, ift_wv_d;

  logic [NUM_WARPS-1:0]                 cand;
  logic                                 gnt_vld, issue;
  logic [WARP_W-1:0]                    gnt_idx, scan_idx;
  logic [ADDR_WIDTH-1:0]                rd_pc;
  logic [SET_W-1:0]                     rd_set, fill_set;
  logic [TAG_W-1:0]                     fill_tag;
  logic [NUM_WAYS-1:0][TAG_W-1:0]       rd_tags;
  logic [NUM_WAYS-1:0]                  rd_wv;
  logic                                 unused_ok;

  assign fill_set  = fill_addr_i[OFS_W +: SET_W];
  assign fill_tag  = fill_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign unused_ok = ^fill_addr_i[OFS_W-1:0];

  // A warp being redirected this cycle must not issue with its stale PC.
  always_comb begin
    cand = warp_active_i;
    if (rollback_en_i) cand[rollback_warp_i] = 1'b0;
    gnt_vld  = 1'b0;
    gnt_idx  = rr_q;
    scan_idx = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr_q + WARP_W'(i);
      if (!gnt_vld && cand[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    issue = !stall_i && gnt_vld;
    rr_d  = issue ? gnt_idx + WARP_W'(1) : rr_q;
  end

  // Tag read with write-first bypass from a same-set fill; inval_all masks old valids.
  always_comb begin
    rd_pc  = pc_q[gnt_idx];
    rd_set = rd_pc[OFS_W +: SET_W];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (fill_en_i && fill_set == rd_set && fill_way_i == WAY_W'(w)) begin
        rd_tags[w] = fill_tag;
        rd_wv[w]   = 1'b1;
      end else begin
        rd_tags[w] = tag_mem[rd_set][w];
        rd_wv[w]   = !inval_all_i && valid_q[rd_set][w];
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (issue) pc_d[gnt_idx] = pc_q[gnt_idx] + ADDR_WIDTH'(4);
    if (rollback_en_i) pc_d[rollback_warp_i] = rollback_pc_i;

    valid_d = valid_q;
    if (inval_all_i) valid_d = '0;
    if (fill_en_i) valid_d[fill_set][fill_way_i] = 1'b1;
  end

  always_comb begin
    ift_valid_d = ift_valid_q;
    ift_warp_d  = ift_warp_q;
    ift_pc_d    = ift_pc_q;
    ift_tags_d  = ift_tags_q;
    ift_wv_d    = ift_wv_q;
    if (issue) begin
      ift_valid_d = 1'b1;
      ift_warp_d  = gnt_idx;
      ift_pc_d    = rd_pc;
      ift_tags_d  = rd_tags;
      ift_wv_d    = rd_wv;
    end else begin
      if (!stall_i) ift_valid_d = 1'b0;
      // Squash applies even while stalled; the rest of the stage keeps holding.
      if (rollback_en_i && ift_valid_q && ift_warp_q == rollback_warp_i) ift_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= {NUM_WARPS{RESET_PC}};
      valid_q     <= '0;
      rr_q        <= '0;
      ift_valid_q <= 1'b0;
      ift_warp_q  <= '0;
      ift_pc_q    <= '0;
      ift_tags_q  <= '0;
      ift_wv_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      ift_valid_q <= ift_valid_d;
      ift_warp_q  <= ift_warp_d;
      ift_pc_q    <= ift_pc_d;
      ift_tags_q  <= ift_tags_d;
      ift_wv_q    <= ift_wv_d;
    end
  end

  // Tag array models an SRAM: no reset, contents qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) tag_mem[fill_set][fill_way_i] <= fill_tag;
  end

  assign ift_valid_o     = ift_valid_q;
  assign ift_warp_idx_o  = ift_warp_q;
  assign ift_pc_o        = ift_pc_q;
  assign ift_tags_o      = ift_tags_q;
  assign ift_way_valid_o = ift_wv_q;

endmodule

// File: tb/tb_ifetch_tag_stage.sv
// Directed bench for ifetch_tag_stage at default parameters (4 warps, 4 ways, 64 sets, 64B lines).
module tb_ifetch_tag_stage;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        warp_active;
  logic              stall, rollback_en, fill_en, inval_all;
  logic [1:0]        rollback_warp, fill_way;
  logic [31:0]       rollback_pc, fill_addr;
  logic              ift_valid;
  logic [1:0]        ift_warp_idx;
  logic [31:0]       ift_pc;
  logic [3:0][19:0]  ift_tags;
  logic [3:0]        ift_way_valid;

  int checks = 0;
  int errors = 0;

  ifetch_tag_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .warp_active_i(warp_active), .stall_i(stall),
    .rollback_en_i(rollback_en), .rollback_warp_i(rollback_warp), .rollback_pc_i(rollback_pc),
    .fill_en_i(fill_en), .fill_way_i(fill_way), .fill_addr_i(fill_addr), .inval_all_i(inval_all),
    .ift_valid_o(ift_valid), .ift_warp_idx_o(ift_warp_idx), .ift_pc_o(ift_pc),
    .ift_tags_o(ift_tags), .ift_way_valid_o(ift_way_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    warp_active = 4'b0; stall = 1'b0; rollback_en = 1'b0; rollback_warp = 2'd0;
    rollback_pc = 32'h0; fill_en = 1'b0; fill_way = 2'd0; fill_addr = 32'h0; inval_all = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ift_valid !== 1'b0 || ift_warp_idx !== 2'd0 || ift_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%0b w=%0d pc=%0h, need 0/0/0", ift_valid, ift_warp_idx, ift_pc);
    end
    checks++;
    if (ift_tags !== '0 || ift_way_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_data: got tags=%0h wv=%0b, need 0/0", ift_tags, ift_way_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  ew [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] ep [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4};
    do_reset();
    warp_active = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (ift_valid !== 1'b1 || ift_warp_idx !== ew[i] || ift_pc !== ep[i]) begin
        errors++;
        $display("FAIL rr[%0d]: got v=%0b w=%0d pc=%0h, need 1/%0d/%0h", i, ift_valid, ift_warp_idx, ift_pc, ew[i], ep[i]);
      end
    end
    // Asynchronous reset mid-stream drops the live fetch immediately.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ift_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got v=%0b, need 0", ift_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [1:0]  ew [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [31:0] ep [4] = '{32'h0, 32'h0, 32'h4, 32'h4};
    do_reset();
    warp_active = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ift_valid !== 1'b1 || ift_warp_idx !== ew[i] || ift_pc !== ep[i]) begin
        errors++;
        $display("FAIL alt[%0d]: got v=%0b w=%0d pc=%0h, need 1/%0d/%0h", i, ift_valid, ift_warp_idx, ift_pc, ew[i], ep[i]);
      end
    end
    warp_active = 4'b0001;
    tick();
    checks++;
    if (ift_warp_idx !== 2'd0 || ift_pc !== 32'h0) begin
      errors++;
      $display("FAIL alt_w0_pc: got w=%0d pc=%0h, need 0/0", ift_warp_idx, ift_pc);
    end
    warp_active = 4'b0100;
    tick();
    checks++;
    if (ift_warp_idx !== 2'd2 || ift_pc !== 32'h0) begin
      errors++;
      $display("FAIL alt_w2_pc: got w=%0d pc=%0h, need 2/0", ift_warp_idx, ift_pc);
    end
    warp_active = 4'b0000;
    tick();
    checks++;
    if (ift_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_grant: got v=%0b, need 0", ift_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    fill_en = 1'b1; fill_way = 2'd0; fill_addr = 32'h0;
    tick();
    fill_en = 1'b0;
    warp_active = 4'b1111;
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (ift_warp_idx !== 2'd2 || ift_pc !== 32'h8 || ift_way_valid !== 4'b0001) begin
      errors++;
      $display("FAIL pre_stall: got w=%0d pc=%0h wv=%0b, need 2/8/0001", ift_warp_idx, ift_pc, ift_way_valid);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ift_valid !== 1'b1 || ift_warp_idx !== 2'd2 || ift_pc !== 32'h8 ||
          ift_way_valid !== 4'b0001 || ift_tags[0] !== 20'h0) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%0b w=%0d pc=%0h wv=%0b t0=%0h, need 1/2/8/0001/0",
                 i, ift_valid, ift_warp_idx, ift_pc, ift_way_valid, ift_tags[0]);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ift_warp_idx !== 2'd3 || ift_pc !== 32'h8) begin
      errors++;
      $display("FAIL post_stall0: got w=%0d pc=%0h, need 3/8", ift_warp_idx, ift_pc);
    end
    tick();
    checks++;
    if (ift_warp_idx !== 2'd0 || ift_pc !== 32'hC) begin
      errors++;
      $display("FAIL post_stall1: got w=%0d pc=%0h, need 0/c", ift_warp_idx, ift_pc);
    end
  endtask

  task automatic test_rollback();
    logic [1:0]  ew [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] ep [8] = '{32'h0, 32'h0, 32'h4, 32'h100, 32'h4, 32'h4, 32'h8, 32'h104};
    do_reset();
    warp_active = 4'b1111;
    tick();
    tick();
    checks++;
    if (ift_warp_idx !== 2'd1 || ift_valid !== 1'b1) begin
      errors++;
      $display("FAIL rb_pre: got w=%0d v=%0b, need 1/1", ift_warp_idx, ift_valid);
    end
    stall = 1'b1; rollback_en = 1'b1; rollback_warp = 2'd1; rollback_pc = 32'h100;
    tick();
    checks++;
    if (ift_valid !== 1'b0) begin
      errors++;
      $display("FAIL rb_squash: got v=%0b, need 0", ift_valid);
    end
    stall = 1'b0; rollback_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (ift_valid !== 1'b1 || ift_warp_idx !== ew[i] || ift_pc !== ep[i]) begin
        errors++;
        $display("FAIL rb_seq[%0d]: got v=%0b w=%0d pc=%0h, need 1/%0d/%0h", i, ift_valid, ift_warp_idx, ift_pc, ew[i], ep[i]);
      end
    end
  endtask

  task automatic test_fill_bypass();
    do_reset();
    rollback_en = 1'b1; rollback_warp = 2'd0; rollback_pc = 32'h1040;
    tick();
    rollback_en = 1'b0;
    warp_active = 4'b0001; fill_en = 1'b1; fill_way = 2'd2; fill_addr = 32'h1040;
    tick();
    checks++;
    if (ift_valid !== 1'b1 || ift_pc !== 32'h1040 || ift_way_valid !== 4'b0100 || ift_tags[2] !== 20'h1) begin
      errors++;
      $display("FAIL bypass: got v=%0b pc=%0h wv=%0b t2=%0h, need 1/1040/0100/1", ift_valid, ift_pc, ift_way_valid, ift_tags[2]);
    end
    fill_en = 1'b0;
    tick();
    checks++;
    if (ift_pc !== 32'h1044 || ift_way_valid !== 4'b0100 || ift_tags[2] !== 20'h1) begin
      errors++;
      $display("FAIL fill_read: got pc=%0h wv=%0b t2=%0h, need 1044/0100/1", ift_pc, ift_way_valid, ift_tags[2]);
    end
  endtask

  task automatic test_inval();
    do_reset();
    fill_en = 1'b1; fill_way = 2'd0; fill_addr = 32'h2000;
    tick();
    fill_way = 2'd1; fill_addr = 32'h3000;
    tick();
    fill_en = 1'b0; warp_active = 4'b0001;
    tick();
    checks++;
    if (ift_way_valid !== 4'b0011 || ift_tags[0] !== 20'h2 || ift_tags[1] !== 20'h3) begin
      errors++;
      $display("FAIL two_fills: got wv=%0b t0=%0h t1=%0h, need 0011/2/3", ift_way_valid, ift_tags[0], ift_tags[1]);
    end
    warp_active = 4'b0000; inval_all = 1'b1;
    tick();
    inval_all = 1'b0; warp_active = 4'b0001;
    tick();
    checks++;
    if (ift_pc !== 32'h4 || ift_way_valid !== 4'b0000) begin
      errors++;
      $display("FAIL after_inval: got pc=%0h wv=%0b, need 4/0000", ift_pc, ift_way_valid);
    end
    inval_all = 1'b1; fill_en = 1'b1; fill_way = 2'd3; fill_addr = 32'h4000;
    tick();
    checks++;
    if (ift_pc !== 32'h8 || ift_way_valid !== 4'b1000 || ift_tags[3] !== 20'h4) begin
      errors++;
      $display("FAIL inval_fill_same: got pc=%0h wv=%0b t3=%0h, need 8/1000/4", ift_pc, ift_way_valid, ift_tags[3]);
    end
    inval_all = 1'b0; fill_en = 1'b0;
    tick();
    checks++;
    if (ift_pc !== 32'hC || ift_way_valid !== 4'b1000 || ift_tags[3] !== 20'h4) begin
      errors++;
      $display("FAIL inval_fill_after: got pc=%0h wv=%0b t3=%0h, need c/1000/4", ift_pc, ift_way_valid, ift_tags[3]);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_alternate();
    test_stall();
    test_rollback();
    test_fill_bypass();
    test_inval();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
